fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queue entries; it must be a power of two and at least 2.
REQ-002 SHALL have parameter ADDR_LEN, default 32, meaning the PC width.
REQ-003 SHALL have parameter INSN_LEN, default 32, meaning the instruction width.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port kill_i, input, 1 bit: flush request (redirect or mispredict).
REQ-007 SHALL have port enq_valid_i, input, 1 bit: the fetch stage presents an entry.
REQ-008 SHALL have port enq_pc_i, input, ADDR_LEN bits: PC of the presented instruction.
REQ-009 SHALL have port enq_inst_i, input, INSN_LEN bits: the presented instruction word.
REQ-010 SHALL have port enq_ready_o, output, 1 bit: the queue accepts an entry this cycle.
REQ-011 SHALL have port stall_IF_o, output, 1 bit: back-pressure to the fetch stage.
REQ-012 SHALL have port deq_valid_o, output, 1 bit: the head entry is valid for decode.
REQ-013 SHALL have port deq_pc_o, output, ADDR_LEN bits: PC of the head entry.
REQ-014 SHALL have port deq_inst_o, output, INSN_LEN bits: instruction of the head entry.
REQ-015 SHALL have port deq_ready_i, input, 1 bit: decode consumes the head entry.
REQ-016 SHALL have port count_o, output, clog2(DEPTH)+1 bits: the current occupancy.

Function
REQ-017 SHALL be a show-ahead FIFO: head pointer, tail pointer and count registers, plus DEPTH storage entries, each holding a PC and an instruction.
REQ-018 SHALL enqueue when enq_valid_i && enq_ready_o && !kill_i: write the entry at the tail and advance the tail by 1, modulo DEPTH.
REQ-019 SHALL dequeue when deq_valid_o && deq_ready_i && !kill_i: advance the head by 1, modulo DEPTH.
REQ-020 SHALL drive enq_ready_o = (count != DEPTH) and stall_IF_o = !enq_ready_o, both purely from registered state.
REQ-021 SHALL drive deq_valid_o = (count != 0), with deq_pc_o/deq_inst_o taken combinationally from the entry at the head pointer.
REQ-022 SHALL drive deq_pc_o and deq_inst_o to 0 when count == 0.
REQ-023 SHALL have no empty bypass: an entry enqueued in cycle N becomes visible at the head in cycle N+1 at the earliest (latency 1).
REQ-024 SHALL update count as +1 on enqueue only, -1 on dequeue only, and unchanged on simultaneous enqueue and dequeue.
REQ-025 SHALL refuse enqueue when full, even if a dequeue occurs in the same cycle; the freed slot becomes available the next cycle.
REQ-026 SHALL, when empty with deq_ready_i high, perform no dequeue and leave the pointers unchanged.
REQ-027 SHALL, when kill_i is high, set head, tail and count to 0 on the next edge and ignore any same-cycle enqueue or dequeue; storage contents are not cleared.
REQ-028 SHALL wrap pointers from DEPTH-1 to 0 with no loss or reordering of entries.
REQ-029 SHALL, when enq_valid_i is low, leave storage and the tail pointer unchanged.

Reset
REQ-030 SHALL, when reset_i is high at a rising edge, set head=0, tail=0 and count=0, giving enq_ready_o=1, stall_IF_o=0, deq_valid_o=0, deq_pc_o=0, deq_inst_o=0 and count_o=0.
REQ-031 SHALL give reset_i priority over kill_i, enqueue and dequeue; reset mid-operation discards all entries.

Verification
REQ-032 SHALL cover fill: DEPTH=4, enqueue PCs 0x100, 0x104, 0x108, 0x10C with deq_ready_i=0 -> count_o=4, enq_ready_o=0, stall_IF_o=1, deq_pc_o=0x100.
REQ-033 SHALL cover full with simultaneous request: full queue, enq_valid_i=1 and deq_ready_i=1 -> only the dequeue happens, count_o=3, enq_ready_o=1 the next cycle, head=0x104.
REQ-034 SHALL cover streaming: enq_valid_i=1 and deq_ready_i=1 for 10 cycles starting empty -> deq_valid_o rises one cycle after the first enqueue, count_o stays at 1, PCs exit in order across the pointer wrap.
REQ-035 SHALL cover kill: kill_i pulsed with 3 entries queued plus an enqueue in the same cycle -> next cycle count_o=0, deq_valid_o=0, deq_inst_o=0, enq_ready_o=1.
REQ-036 SHALL cover empty dequeue: deq_ready_i=1 while empty for 3 cycles, then one enqueue with inst 0x00000013 -> no underflow, count_o=1, deq_inst_o=0x00000013.
REQ-037 SHALL cover reset mid-stream: reset_i high with 2 entries queued -> all outputs at the REQ-030 values the next cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - show-ahead instruction queue between fetch and decode
//
// Ports:
//   clk_i        rising-edge clock
//   reset_i      synchronous active-high reset (beats kill, enqueue, dequeue)
//   kill_i       flush: empties the queue on the next edge, same-cycle traffic ignored
//   enq_valid_i  fetch presents {enq_pc_i, enq_inst_i}
//   enq_ready_o  queue can accept an entry this cycle (not full)
//   stall_IF_o   back-pressure to fetch, the inverse of enq_ready_o
//   deq_valid_o  head entry is valid; deq_pc_o / deq_inst_o show it (0 when empty)
//   deq_ready_i  decode consumes the head entry
//   count_o      current occupancy, 0..DEPTH

module fetch_queue #(
    parameter int DEPTH    = 4,
    parameter int ADDR_LEN = 32,
    parameter int INSN_LEN = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      kill_i,

    input  logic                      enq_valid_i,
    input  logic [ADDR_LEN-1:0]       enq_pc_i,
    input  logic [INSN_LEN-1:0]       enq_inst_i,
    output logic                      enq_ready_o,
    output logic                      stall_IF_o,

    output logic                      deq_valid_o,
    output logic [ADDR_LEN-1:0]       deq_pc_o,
    output logic [INSN_LEN-1:0]       deq_inst_o,
    input  logic                      deq_ready_i,

    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [ADDR_LEN-1:0] pc_mem_q   [DEPTH];
    logic [INSN_LEN-1:0] inst_mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic not_full;
    logic not_empty;
    logic enq_fire;
    logic deq_fire;

    // Both flags come only from the registered count, so a dequeue in the
    // same cycle never opens a slot for a full queue until the next edge.
    assign not_full  = (count_q != CNT_FULL);
    assign not_empty = (count_q != '0);

    assign enq_fire = enq_valid_i && not_full  && !kill_i;
    assign deq_fire = not_empty   && deq_ready_i && !kill_i;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // DEPTH is a power of two, so the pointers wrap naturally at PTR_W bits.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (kill_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) begin
                tail_d = tail_q + PTR_ONE;
            end
            if (deq_fire) begin
                head_d = head_q + PTR_ONE;
            end
            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pointer / count registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage: no reset, contents only matter between head and tail.
    // A kill or reset only moves the pointers; stale data stays behind.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_i && enq_fire) begin
            pc_mem_q[tail_q]   <= enq_pc_i;
            inst_mem_q[tail_q] <= enq_inst_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign enq_ready_o = not_full;
    assign stall_IF_o  = !not_full;
    assign deq_valid_o = not_empty;
    assign count_o     = count_q;

    // Head data is read straight from storage (show-ahead) but forced to
    // zero when empty so decode never sees a stale entry.
    assign deq_pc_o   = not_empty ? pc_mem_q[head_q]   : '0;
    assign deq_inst_o = not_empty ? inst_mem_q[head_q] : '0;

endmodule
